pio_mux_ctrl: RTL and testbench

Parametrised per-pin I/O multiplexer and input-event block for the MKR/NINA/PCIe pin banks.
- Each pad is driven by the plain PIO (out/dir) or by one of NSRC-1 peripheral sources.
- Glitch-free switching: the pad is released to high-Z for a guard interval whenever its select changes.
- The block synchronises pad inputs and raises per-pin edge interrupts towards the SAM IRQ line.
- It sits between the Qsys PIO/peripheral outputs and the top-level tristate pads, one instance per bank.

---
 rtl/pio_mux_pkg.sv | 19 +
 rtl/pio_mux_lane.sv | 115 +++++++++++
 rtl/pio_mux_ctrl.sv | 69 ++++++
 tb/tb_pio_mux_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pio_mux_pkg.sv
// pio_mux_pkg: shared lane state type, select constants and parameter helpers for pio_mux_ctrl.
package pio_mux_pkg;

    typedef enum logic {ST_IDLE, ST_GUARD} lane_state_e;

    localparam int MSEL_PIO = 0;

    // Peripheral source src (1..NSRC-1) for pin lives at this bit of the flat iALT_OUT bus.
    function automatic int alt_idx(input int src, input int pin, input int npin);
        return (src - 1) * npin + pin;
    endfunction

    function automatic bit params_ok(input int npin, input int nsrc, input int selw,
                                     input int sync_stages, input int guard);
        return npin >= 1 && npin <= 32 && nsrc >= 2 && nsrc <= 16 && (1 << selw) >= nsrc &&
               sync_stages >= 2 && sync_stages <= 4 && guard >= 0 && guard <= 15;
    endfunction

endpackage

// File: rtl/pio_mux_lane.sv
// pio_mux_lane: one pad - input synchroniser, edge-event pending flag, guarded source-select FSM and output register.
module pio_mux_lane
    import pio_mux_pkg::*;
#(
    parameter int NSRC         = 4,
    parameter int SELW         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pin_i,
    input  logic            pio_out_i,
    input  logic            pio_dir_i,
    input  logic [SELW-1:0] msel_i,
    input  logic [NSRC-2:0] alt_i,
    input  logic            rise_en_i,
    input  logic            fall_en_i,
    input  logic            clr_i,
    output logic            pin_out_o,
    output logic            pin_oe_o,
    output logic            pio_in_o,
    output logic            pend_o
);

    localparam int NCODE = 1 << SELW;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pend_q, pend_d;
    logic                   rise, fall;
    lane_state_e            state_q, state_d;
    logic [3:0]             gcnt_q, gcnt_d;
    logic [SELW-1:0]        sel_q, sel_d;
    logic [NCODE-1:0]       src;
    logic                   oe_q, oe_d, out_q, out_d;

    assign pio_in_o  = sync_q[SYNC_STAGES-1];
    assign rise      = pio_in_o & ~prev_q;
    assign fall      = ~pio_in_o & prev_q;
    // A fresh edge outranks a simultaneous clear so no event is lost.
    assign pend_d    = (pend_q & ~clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
    assign pend_o    = pend_q;
    assign pin_oe_o  = oe_q;
    assign pin_out_o = out_q;

    assign src[0] = pio_out_i;
    for (genvar k = 1; k < NCODE; k++) begin : g_src
        if (k < NSRC) begin : g_legal
            assign src[k] = alt_i[k-1];
        end else begin : g_illegal
            assign src[k] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
            oe_q   <= 1'b0;
            out_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= pio_in_o;
            pend_q <= pend_d;
            oe_q   <= oe_d;
            out_q  <= out_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            gcnt_q  <= 4'd0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            sel_q   <= sel_d;
        end
    end

    // Requests arriving mid-guard only matter at exit: the select is sampled when the count expires.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        sel_d   = sel_q;
        if (state_q == ST_GUARD) begin
            gcnt_d = gcnt_q - 4'd1;
            if (gcnt_q == 4'd0) begin
                state_d = ST_IDLE;
                gcnt_d  = 4'd0;
                sel_d   = msel_i;
            end
        end else if (msel_i != sel_q) begin
            if (GUARD_CYCLES == 0) begin
                sel_d = msel_i;
            end else begin
                state_d = ST_GUARD;
                gcnt_d  = 4'(GUARD_CYCLES - 1);
            end
        end
    end

    always_comb begin
        oe_d  = 1'b0;
        out_d = 1'b0;
        if (state_q == ST_IDLE && 32'(sel_q) < NSRC) begin
            oe_d  = (sel_q == SELW'(MSEL_PIO)) ? pio_dir_i : 1'b1;
            out_d = src[sel_q];
        end
    end

endmodule

// File: rtl/pio_mux_ctrl.sv
// pio_mux_ctrl: per-bank pad multiplexer with glitch-free source switching and synchronised edge interrupts.
module pio_mux_ctrl
    import pio_mux_pkg::*;
#(
    parameter int NPIN         = 32,
    parameter int NSRC         = 4,
    parameter int SELW         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                     iCLK,
    input  logic                     iRESETn,
    input  logic [NPIN-1:0]          iPIN_IN,
    output logic [NPIN-1:0]          oPIN_OUT,
    output logic [NPIN-1:0]          oPIN_OE,
    input  logic [NPIN-1:0]          iPIO_OUT,
    input  logic [NPIN-1:0]          iPIO_DIR,
    input  logic [NPIN*SELW-1:0]     iMSEL,
    input  logic [(NSRC-1)*NPIN-1:0] iALT_OUT,
    output logic [NPIN-1:0]          oPIO_IN,
    input  logic [NPIN-1:0]          iIRQ_RISE_EN,
    input  logic [NPIN-1:0]          iIRQ_FALL_EN,
    input  logic [NPIN-1:0]          iIRQ_CLR,
    output logic [NPIN-1:0]          oIRQ_PEND,
    output logic                     oIRQ
);

    logic irq_q;

    if (!params_ok(NPIN, NSRC, SELW, SYNC_STAGES, GUARD_CYCLES)) begin : g_bad_params
        $error("pio_mux_ctrl: illegal parameter combination");
    end

    for (genvar i = 0; i < NPIN; i++) begin : g_lane
        logic [NSRC-2:0] alt;
        for (genvar k = 1; k < NSRC; k++) begin : g_alt
            assign alt[k-1] = iALT_OUT[alt_idx(k, i, NPIN)];
        end
        pio_mux_lane #(
            .NSRC         (NSRC),
            .SELW         (SELW),
            .SYNC_STAGES  (SYNC_STAGES),
            .GUARD_CYCLES (GUARD_CYCLES)
        ) u_lane (
            .clk_i     (iCLK),
            .rst_ni    (iRESETn),
            .pin_i     (iPIN_IN[i]),
            .pio_out_i (iPIO_OUT[i]),
            .pio_dir_i (iPIO_DIR[i]),
            .msel_i    (iMSEL[i*SELW +: SELW]),
            .alt_i     (alt),
            .rise_en_i (iIRQ_RISE_EN[i]),
            .fall_en_i (iIRQ_FALL_EN[i]),
            .clr_i     (iIRQ_CLR[i]),
            .pin_out_o (oPIN_OUT[i]),
            .pin_oe_o  (oPIN_OE[i]),
            .pio_in_o  (oPIO_IN[i]),
            .pend_o    (oIRQ_PEND[i])
        );
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) irq_q <= 1'b0;
        else          irq_q <= |oIRQ_PEND;
    end

    assign oIRQ = irq_q;

endmodule

// File: tb/tb_pio_mux_ctrl.sv
// tb_pio_mux_ctrl: directed checks on four bank configurations (guard 2/0/3, and NSRC=3) sharing one stimulus set.
module tb_pio_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pin_in, pio_out, pio_dir, rise_en, fall_en, clr;
    logic [7:0]  msel;
    logic [11:0] alt;
    logic [3:0]  d_out[4], d_oe[4], d_in[4], d_pend[4];
    logic        d_irq[4];
    int          n_run = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: guard 2, instance 1: guard 0, instance 2: guard 3, instance 3: NSRC=3 guard 2.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NS = (g == 3) ? 3 : 4;
        localparam int GC = (g == 1) ? 0 : (g == 2) ? 3 : 2;
        pio_mux_ctrl #(
            .NPIN(4), .NSRC(NS), .SELW(2), .SYNC_STAGES(2), .GUARD_CYCLES(GC)
        ) u_dut (
            .iCLK         (clk),
            .iRESETn      (rst_n),
            .iPIN_IN      (pin_in),
            .oPIN_OUT     (d_out[g]),
            .oPIN_OE      (d_oe[g]),
            .iPIO_OUT     (pio_out),
            .iPIO_DIR     (pio_dir),
            .iMSEL        (msel),
            .iALT_OUT     (alt[(NS-1)*4-1:0]),
            .oPIO_IN      (d_in[g]),
            .iIRQ_RISE_EN (rise_en),
            .iIRQ_FALL_EN (fall_en),
            .iIRQ_CLR     (clr),
            .oIRQ_PEND    (d_pend[g]),
            .oIRQ         (d_irq[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        pin_in  = '0;
        rise_en = '0;
        fall_en = '0;
        clr     = '0;
        msel    = '0;
        pio_out = 4'b0101;
        pio_dir = 4'b1111;
        alt     = 12'h826;
        step(2);
        chk("rst_oe",   d_oe[0], 4'h0);
        chk("rst_pend", d_pend[0], 4'h0);
        chk("rst_irq",  d_irq[0], 1'b0);
        rst_n = 1'b1;
        step();
        chk("rel_oe",  d_oe[0], 4'hF);
        chk("rel_out", d_out[0], 4'b0101);
        // pin 1 select 0 -> 2
        msel = 8'b0000_1000;
        step();
        chk("g2_t1_oe", d_oe[0], 4'hF);
        step();
        chk("g2_t2_oe", d_oe[0], 4'b1101);
        chk("g0_t2_oe", d_oe[1], 4'hF);
        chk("g0_t2_out", d_out[1], 4'b0111);
        step();
        chk("g2_t3_oe", d_oe[0], 4'b1101);
        chk("g3_t3_oe", d_oe[2], 4'b1101);
        step();
        chk("g2_t4_oe", d_oe[0], 4'hF);
        chk("g2_t4_out", d_out[0], 4'b0111);
        chk("g3_t4_oe", d_oe[2], 4'b1101);
        chk("n3_t4_out", d_out[3], 4'b0111);
        step();
        chk("g3_t5_oe", d_oe[2], 4'hF);
        chk("g3_t5_out", d_out[2], 4'b0111);
        // pin 1 retarget 2 -> 1 -> 3 on consecutive cycles
        msel = 8'b0000_0100;
        step();
        msel = 8'b0000_1100;
        step();
        chk("g0_r2_oe", d_oe[1], 4'hF);
        chk("g0_r2_out", d_out[1], 4'b0111);
        chk("g2_r2_oe", d_oe[0], 4'b1101);
        step();
        chk("g0_r3_out", d_out[1], 4'b0101);
        chk("n3_r3_oe", d_oe[3], 4'b1101);
        step();
        chk("g2_r4_oe", d_oe[0], 4'hF);
        chk("g2_r4_out", d_out[0], 4'b0101);
        chk("g3_r4_oe", d_oe[2], 4'b1101);
        chk("n3_ill_oe", d_oe[3], 4'b1101);
        chk("n3_ill_out", d_out[3], 4'b0101);
        step();
        chk("g3_r5_oe", d_oe[2], 4'hF);
        step(2);
        chk("n3_ill_hold", d_oe[3], 4'b1101);
        // rising edge on pin 0
        rise_en = 4'b0001;
        pin_in  = 4'b0001;
        step();
        chk("sync_t1", d_in[0], 4'h0);
        step();
        chk("sync_t2", d_in[0], 4'b0001);
        chk("pend_t2", d_pend[0], 4'h0);
        step();
        chk("pend_t3", d_pend[0], 4'b0001);
        chk("irq_t3", d_irq[0], 1'b0);
        step();
        chk("irq_t4", d_irq[0], 1'b1);
        rise_en = 4'b0000;
        step();
        chk("pend_en_off", d_pend[0], 4'b0001);
        clr = 4'b0001;
        step();
        clr = 4'b0000;
        chk("clr_pend", d_pend[0], 4'h0);
        chk("clr_irq_lag", d_irq[0], 1'b1);
        step();
        chk("clr_irq", d_irq[0], 1'b0);
        // falling edge with fall enable off
        pin_in = 4'b0000;
        step(4);
        chk("fall_off_in", d_in[0], 4'h0);
        chk("fall_off_pend", d_pend[0], 4'h0);
        // clear in the same cycle as a detected rise
        rise_en = 4'b0001;
        pin_in  = 4'b0001;
        step(2);
        clr = 4'b0001;
        step();
        clr = 4'b0000;
        chk("coll_pend", d_pend[0], 4'b0001);
        clr = 4'b0001;
        step();
        clr = 4'b0000;
        chk("coll_clr_pend", d_pend[0], 4'h0);
        chk("coll_clr_irq_lag", d_irq[0], 1'b1);
        step();
        chk("coll_clr_irq", d_irq[0], 1'b0);
        // falling edge with fall enable on, then reset mid-cycle
        fall_en = 4'b0001;
        pin_in  = 4'b0000;
        step(3);
        chk("fall_on_pend", d_pend[0], 4'b0001);
        step();
        chk("fall_on_irq", d_irq[0], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_oe", d_oe[0], 4'h0);
        chk("arst_out", d_out[0], 4'h0);
        chk("arst_pend", d_pend[0], 4'h0);
        chk("arst_irq", d_irq[0], 1'b0);
        msel = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("rel2_oe", d_oe[0], 4'hF);
        chk("rel2_out", d_out[0], 4'b0101);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
